// File: rtl/crubits_pkg.sv
// Shared constants, host FSM state type and CRU address decode helper for crubits_ctrl.
package crubits_pkg;

    // Upper nibble of a CRU address that selects this family of cards.
    localparam logic [3:0] CRU_PREFIX = 4'b0001;
    localparam int unsigned NUM_BITS  = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } host_state_e;

    // True when the synchronised address targets this card and one of its 4 bits
    // (bits 8..12 zero leaves only indices 0..3 via addr[13:14]).
    function automatic logic cru_addr_match(input logic [0:14] addr, input logic [0:3] base);
        return (addr[0:3] == CRU_PREFIX) && (addr[4:7] == base) && (addr[8:12] == 5'd0);
    endfunction

endpackage

// File: rtl/crubits_ctrl_sync.sv
// Brings the asynchronous TI CRU strobe, address and data into the clk domain.
// fe marks the clk cycle in which a falling strobe edge has been seen; addr/data are
// pipelined so they line up with the strobe flop used for the edge decision.
module cru_strobe_sync (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_ti_cru_clk,
    input  logic [0:14] i_addr,
    input  logic        i_ti_cru_out,
    output logic        o_fe,
    output logic [0:14] o_addr_s,
    output logic        o_data_s
);

    logic        r_s1, r_s2, r_s3;
    logic [0:14] r_addr1, r_addr2;
    logic        r_data1, r_data2;

    // Strobe synchroniser plus 2-stage address/data pipeline; strobe resets high (idle level)
    // so reset release never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_s3    <= 1'b1;
            r_addr1 <= '0;
            r_addr2 <= '0;
            r_data1 <= 1'b0;
            r_data2 <= 1'b0;
        end else begin
            r_s1    <= i_ti_cru_clk;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_addr1 <= i_addr;
            r_addr2 <= r_addr1;
            r_data1 <= i_ti_cru_out;
            r_data2 <= r_data1;
        end
    end

    assign o_fe     = r_s3 & ~r_s2;
    assign o_addr_s = r_addr2;
    assign o_data_s = r_data2;

endmodule

// File: rtl/crubits_ctrl.sv
// CRU output bit register shared between TI CRU writes and a 4-phase host handshake,
// with one self-clearing pulse bit and a change-notification strobe.
module crubits_ctrl
    import crubits_pkg::*;
#(
    parameter int unsigned PULSE_BIT    = 1,
    parameter int unsigned PULSE_CYCLES = 1000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:3]  cru_base,
    input  logic        ti_cru_clk,
    input  logic [0:14] addr,
    input  logic        ti_cru_out,
    input  logic        pi_req,
    input  logic [1:0]  pi_bit,
    input  logic        pi_val,
    output logic        pi_ack,
    output logic [0:3]  bits,
    output logic        bits_changed
);

    localparam logic [1:0] PB       = 2'(PULSE_BIT);
    localparam logic       PULSE_EN = (PULSE_CYCLES != 0);

    logic [0:NUM_BITS-1] r_bits, w_bits_d;
    logic [CNT_W-1:0]    r_cnt, w_cnt_d;
    host_state_e         r_state, w_state_d;
    logic                r_ack, w_ack_d;
    logic                r_changed;

    logic        w_fe;
    logic [0:14] w_addr_s;
    logic        w_data_s;
    logic        w_ti_hit;
    logic        w_we;
    logic [1:0]  w_widx;
    logic        w_wval;

    cru_strobe_sync u_sync (
        .clk          (clk),
        .reset        (reset),
        .i_ti_cru_clk (ti_cru_clk),
        .i_addr       (addr),
        .i_ti_cru_out (ti_cru_out),
        .o_fe         (w_fe),
        .o_addr_s     (w_addr_s),
        .o_data_s     (w_data_s)
    );

    assign w_ti_hit = w_fe & cru_addr_match(w_addr_s, cru_base);

    // Next state: auto-clear first, then a single write (TI has priority over the host).
    always_comb begin
        w_bits_d  = r_bits;
        w_cnt_d   = r_cnt;
        w_state_d = r_state;
        w_ack_d   = r_ack;
        w_we      = 1'b0;
        w_widx    = '0;
        w_wval    = 1'b0;

        if (PULSE_EN && (r_cnt != '0)) begin
            w_cnt_d = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                w_bits_d[PB] = 1'b0;
            end
        end

        if (w_ti_hit) begin
            w_we   = 1'b1;
            w_widx = w_addr_s[13:14];
            w_wval = w_data_s;
        end

        unique case (r_state)
            IDLE: begin
                // A TI hit in the same cycle defers the host write; pi_req is still high next cycle.
                if (pi_req && !w_ti_hit) begin
                    w_we      = 1'b1;
                    w_widx    = pi_bit;
                    w_wval    = pi_val;
                    w_ack_d   = 1'b1;
                    w_state_d = ACK;
                end
            end
            ACK: begin
                if (!pi_req) begin
                    w_ack_d   = 1'b0;
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_ack_d   = 1'b0;
                w_state_d = IDLE;
            end
        endcase

        // A write overrides a same-cycle auto-clear and (re)starts or cancels the pulse.
        if (w_we) begin
            w_bits_d[w_widx] = w_wval;
            if (PULSE_EN && (w_widx == PB)) begin
                w_cnt_d = w_wval ? CNT_W'(PULSE_CYCLES) : '0;
            end
        end
    end

    // State registers; bits_changed flags any value change committed on this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bits    <= '0;
            r_cnt     <= '0;
            r_state   <= IDLE;
            r_ack     <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_bits    <= w_bits_d;
            r_cnt     <= w_cnt_d;
            r_state   <= w_state_d;
            r_ack     <= w_ack_d;
            r_changed <= (w_bits_d != r_bits);
        end
    end

    assign bits         = r_bits;
    assign pi_ack       = r_ack;
    assign bits_changed = r_changed;

endmodule

// File: tb/tb_crubits_ctrl.sv
// Directed bench for crubits_ctrl: a vector table of single writes plus hand-written
// sequences for latency, arbitration, pulse timing and reset.
module tb_crubits_ctrl;

    logic        clk;
    logic        reset;
    logic [0:3]  cru_base;
    logic        ti_cru_clk;
    logic [0:14] addr;
    logic        ti_cru_out;
    logic        pi_req;
    logic [1:0]  pi_bit;
    logic        pi_val;
    logic        pi_ack;
    logic [0:3]  bits;
    logic        bits_changed;

    int n_checks = 0;
    int n_fail   = 0;
    int chg_cnt  = 0;

    crubits_ctrl #(
        .PULSE_BIT    (1),
        .PULSE_CYCLES (8),
        .CNT_W        (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cru_base     (cru_base),
        .ti_cru_clk   (ti_cru_clk),
        .addr         (addr),
        .ti_cru_out   (ti_cru_out),
        .pi_req       (pi_req),
        .pi_bit       (pi_bit),
        .pi_val       (pi_val),
        .pi_ack       (pi_ack),
        .bits         (bits),
        .bits_changed (bits_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts bits_changed pulses (one count per high cycle).
    always @(posedge clk) begin
        if (bits_changed === 1'b1) chg_cnt <= chg_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        is_ti;
        logic [14:0] a;
        logic        data;
        logic [1:0]  pbit;
        logic        pval;
        logic [3:0]  exp_bits;
        int          exp_chg;
        string       name;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] bv();
        logic [3:0] b;
        b = bits;
        return b;
    endfunction

    function automatic logic [14:0] mk_addr(input logic [3:0] base, input logic [6:0] low);
        return {4'b0001, base, low};
    endfunction

    task automatic ti_strobe(input logic [14:0] a, input logic d);
        addr       = a;
        ti_cru_out = d;
        tick();
        ti_cru_clk = 1'b0;
        repeat (3) tick();
        ti_cru_clk = 1'b1;
        repeat (3) tick();
    endtask

    task automatic host_write(input logic [1:0] b, input logic v, input logic [3:0] exp,
                              input string name);
        pi_bit = b;
        pi_val = v;
        pi_req = 1'b1;
        tick();
        chk({name, "_ack_set"}, 32'(pi_ack), 32'd1);
        chk({name, "_bits"}, 32'(bv()), 32'(exp));
        tick();
        chk({name, "_ack_hold"}, 32'(pi_ack), 32'd1);
        pi_req = 1'b0;
        tick();
        chk({name, "_ack_drop"}, 32'(pi_ack), 32'd0);
    endtask

    initial begin
        int base;

        vecs[0] = '{1'b1, mk_addr(4'h3, 7'd2), 1'b1, 2'd0, 1'b0, 4'b0000, 0, "ti_base_mismatch"};
        vecs[1] = '{1'b1, mk_addr(4'h2, 7'h04), 1'b1, 2'd0, 1'b0, 4'b0000, 0, "ti_index_4"};
        vecs[2] = '{1'b0, 15'd0, 1'b0, 2'd3, 1'b1, 4'b0001, 1, "host_b3_set"};
        vecs[3] = '{1'b0, 15'd0, 1'b0, 2'd0, 1'b1, 4'b1001, 1, "host_b0_set"};
        vecs[4] = '{1'b0, 15'd0, 1'b0, 2'd0, 1'b1, 4'b1001, 0, "host_b0_same"};
        vecs[5] = '{1'b1, mk_addr(4'h2, 7'd2), 1'b1, 2'd0, 1'b0, 4'b1011, 1, "ti_b2_set"};
        vecs[6] = '{1'b1, mk_addr(4'h2, 7'd3), 1'b0, 2'd0, 1'b0, 4'b1010, 1, "ti_b3_clr"};
        vecs[7] = '{1'b0, 15'd0, 1'b0, 2'd2, 1'b0, 4'b1000, 1, "host_b2_clr"};
        vecs[8] = '{1'b0, 15'd0, 1'b0, 2'd0, 1'b0, 4'b0000, 1, "host_b0_clr"};

        reset      = 1'b1;
        cru_base   = 4'h2;
        ti_cru_clk = 1'b1;
        addr       = '0;
        ti_cru_out = 1'b0;
        pi_req     = 1'b0;
        pi_bit     = '0;
        pi_val     = 1'b0;
        repeat (3) tick();
        chk("rst_bits", 32'(bv()), 32'd0);
        chk("rst_ack", 32'(pi_ack), 32'd0);
        chk("rst_changed", 32'(bits_changed), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // TI write of bit1 (the pulse bit): 3-edge latency, then auto-clear after 8 cycles.
        addr       = mk_addr(4'h2, 7'd1);
        ti_cru_out = 1'b1;
        tick();
        ti_cru_clk = 1'b0;
        repeat (2) tick();
        chk("ti_lat_before", 32'(bv()), 32'b0000);
        tick();
        chk("ti_lat_bits", 32'(bv()), 32'b0100);
        chk("ti_lat_changed", 32'(bits_changed), 32'd1);
        tick();
        chk("ti_changed_1cyc", 32'(bits_changed), 32'd0);
        ti_cru_clk = 1'b1;
        repeat (6) tick();
        chk("ti_pulse_held", 32'(bv()), 32'b0100);
        tick();
        chk("ti_pulse_clear", 32'(bv()), 32'b0000);
        chk("ti_pulse_clear_chg", 32'(bits_changed), 32'd1);
        repeat (2) tick();

        // Table of single writes from either source.
        for (int i = 0; i < 9; i++) begin
            base = chg_cnt;
            if (vecs[i].is_ti) ti_strobe(vecs[i].a, vecs[i].data);
            else host_write(vecs[i].pbit, vecs[i].pval, vecs[i].exp_bits, vecs[i].name);
            repeat (2) tick();
            chk({vecs[i].name, "_final"}, 32'(bv()), 32'(vecs[i].exp_bits));
            chk({vecs[i].name, "_nchg"}, 32'(chg_cnt - base), 32'(vecs[i].exp_chg));
        end

        // Same-cycle TI hit (bit0<=1) and host request (bit0<=0): TI first, host one cycle later.
        addr       = mk_addr(4'h2, 7'd0);
        ti_cru_out = 1'b1;
        tick();
        ti_cru_clk = 1'b0;
        repeat (2) tick();
        pi_bit = 2'd0;
        pi_val = 1'b0;
        pi_req = 1'b1;
        tick();
        chk("arb_ti_first", 32'(bv()), 32'b1000);
        chk("arb_ack_late", 32'(pi_ack), 32'd0);
        tick();
        chk("arb_host_next", 32'(bv()), 32'b0000);
        chk("arb_ack_set", 32'(pi_ack), 32'd1);
        ti_cru_clk = 1'b1;
        pi_req     = 1'b0;
        tick();
        chk("arb_ack_drop", 32'(pi_ack), 32'd0);
        repeat (4) tick();

        // Host sets pulse bit at E0, rewrites it at E5: high until E13.
        pi_bit = 2'd1;
        pi_val = 1'b1;
        pi_req = 1'b1;
        tick();
        chk("pulse_set", 32'(bv()), 32'b0100);
        pi_req = 1'b0;
        tick();
        repeat (3) tick();
        pi_req = 1'b1;
        tick();
        chk("pulse_rewrite_ack", 32'(pi_ack), 32'd1);
        chk("pulse_rewrite_nochg", 32'(bits_changed), 32'd0);
        pi_req = 1'b0;
        tick();
        repeat (6) tick();
        chk("pulse_ext_held", 32'(bv()), 32'b0100);
        tick();
        chk("pulse_ext_clear", 32'(bv()), 32'b0000);
        chk("pulse_ext_chg", 32'(bits_changed), 32'd1);
        repeat (2) tick();

        // Reset during ACK with all bits set.
        host_write(2'd0, 1'b1, 4'b1000, "rst_prep0");
        host_write(2'd2, 1'b1, 4'b1010, "rst_prep2");
        host_write(2'd3, 1'b1, 4'b1011, "rst_prep3");
        pi_bit = 2'd1;
        pi_val = 1'b1;
        pi_req = 1'b1;
        tick();
        chk("rst_ack_state", 32'(pi_ack), 32'd1);
        chk("rst_all_set", 32'(bv()), 32'b1111);
        reset = 1'b1;
        tick();
        chk("rst_mid_bits", 32'(bv()), 32'd0);
        chk("rst_mid_ack", 32'(pi_ack), 32'd0);
        pi_req = 1'b0;
        tick();
        reset = 1'b0;
        repeat (2) tick();

        // TI strobe whose write is still in the synchroniser when reset hits: it must vanish.
        base       = chg_cnt;
        addr       = mk_addr(4'h2, 7'd2);
        ti_cru_out = 1'b1;
        tick();
        ti_cru_clk = 1'b0;
        tick();
        reset = 1'b1;
        repeat (2) tick();
        ti_cru_clk = 1'b1;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("straddle_bits", 32'(bv()), 32'd0);
        chk("straddle_nchg", 32'(chg_cnt - base), 32'd0);
        chk("straddle_ack", 32'(pi_ack), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
